// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: owns the PC, fetches one word at a time,
// hands it to decode and halts with a sticky fault on a misaligned next PC.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic [31:0] next_pc,
  input  logic        stall,
  output logic [31:0] i_fetch,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        fetch_fault,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   take_word;
  logic   handoff;
  logic   misaligned;

  assign misaligned = (next_pc[1:0] != 2'b00);
  assign imem_addr  = pc;

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    take_word = 1'b0;
    handoff   = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          take_word = 1'b1;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (!stall) begin
          handoff   = 1'b1;
          state_nxt = misaligned ? S_FAULT : S_FETCH;
        end
      end
      S_FAULT: state_nxt = S_FAULT;
      default: state_nxt = S_FETCH;
    endcase
    // A request must never be visible while reset is held, even though state is already FETCH.
    if (reset) begin
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      i_fetch     <= 32'h0;
      fetch_valid <= 1'b0;
      fetch_fault <= 1'b0;
      instr_count <= 32'h0;
    end else begin
      state <= state_nxt;
      if (take_word) begin
        i_fetch     <= imem_rdata;
        fetch_valid <= 1'b1;
      end
      // The offending PC is still loaded on a fault so it can be inspected afterwards.
      if (handoff) begin
        instr_count <= instr_count + 32'd1;
        fetch_valid <= 1'b0;
        pc          <= next_pc;
        if (misaligned) begin
          fetch_fault <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage: vector table, corner sequences,
// randomized run against a transaction-level reference model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] next_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] i_fetch;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        fetch_fault;
  logic [31:0] instr_count;

  fetch_stage #(.RESET_PC(RPC)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .next_pc     (next_pc),
    .stall       (stall),
    .i_fetch     (i_fetch),
    .pc          (pc),
    .fetch_valid (fetch_valid),
    .fetch_fault (fetch_fault),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [31:0] rd;
    logic        st;
    logic [31:0] npc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    logic        e_fault;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] m_pc;
  logic [31:0] m_inst;
  logic [31:0] m_cnt;
  bit          m_hold;
  bit          m_fault;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, want);
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b required %b", name, got, want);
  endtask

  task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                           input logic e_valid, input logic [31:0] e_inst, input logic [31:0] e_pc,
                           input logic e_fault, input logic [31:0] e_cnt);
    chk1({tag, ".imem_req"}, imem_req, e_req);
    chk({tag, ".imem_addr"}, imem_addr, e_addr);
    chk1({tag, ".fetch_valid"}, fetch_valid, e_valid);
    chk({tag, ".i_fetch"}, i_fetch, e_inst);
    chk({tag, ".pc"}, pc, e_pc);
    chk1({tag, ".fetch_fault"}, fetch_fault, e_fault);
    chk({tag, ".instr_count"}, instr_count, e_cnt);
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic [31:0] rd,
                       input logic st, input logic [31:0] npc);
    reset      = rst;
    imem_ready = rdy;
    imem_rdata = rd;
    stall      = st;
    next_pc    = npc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic rst, input logic rdy, input logic [31:0] rd, input logic st,
                     input logic [31:0] npc, input logic req, input logic [31:0] addr,
                     input logic v, input logic [31:0] inst, input logic [31:0] epc,
                     input logic f, input logic [31:0] cnt);
    vec_t r;
    r = '{rst, rdy, rd, st, npc, req, addr, v, inst, epc, f, cnt};
    vecs.push_back(r);
  endtask

  // Instruction-level behaviour: a word is either being fetched, held for decode, or the stage is dead.
  task automatic model_clock(input logic rst, input logic rdy, input logic [31:0] rd,
                             input logic st, input logic [31:0] npc);
    if (rst) begin
      m_pc = RPC; m_inst = 32'h0; m_cnt = 32'h0; m_hold = 0; m_fault = 0;
    end else if (m_fault) begin
      m_fault = 1;
    end else if (m_hold) begin
      if (!st) begin
        m_cnt  = m_cnt + 32'd1;
        m_hold = 0;
        m_pc   = npc;
        if (npc % 4 != 0) m_fault = 1;
      end
    end else if (rdy) begin
      m_inst = rd;
      m_hold = 1;
    end
  endtask

  initial begin
    logic        r_rst, r_rdy, r_st;
    logic [31:0] r_rd, r_npc;

    // Reset state
    drive(1, 1, 32'hFFFF_FFFF, 0, 32'h4);
    tick();
    tick();
    check_all("reset", 0, RPC, 0, 32'h0, RPC, 0, 32'h0);

    // Straight-line run, 3-cycle wait states, stall hold at 0x40, jump to 0x100, misaligned 0x102
    add(0, 1, 32'h1111_1111, 0, 32'h4,   1, 32'h0,   0, 32'h0,         32'h0,   0, 0);
    add(0, 0, 32'h0,         0, 32'h4,   0, 32'h0,   1, 32'h1111_1111, 32'h0,   0, 0);
    add(0, 1, 32'h2222_2222, 0, 32'h8,   1, 32'h4,   0, 32'h1111_1111, 32'h4,   0, 1);
    add(0, 0, 32'h0,         0, 32'h8,   0, 32'h4,   1, 32'h2222_2222, 32'h4,   0, 1);
    add(0, 1, 32'h3333_3333, 0, 32'hC,   1, 32'h8,   0, 32'h2222_2222, 32'h8,   0, 2);
    add(0, 0, 32'h0,         0, 32'hC,   0, 32'h8,   1, 32'h3333_3333, 32'h8,   0, 2);
    add(0, 0, 32'h0,         0, 32'hC,   1, 32'hC,   0, 32'h3333_3333, 32'hC,   0, 3);
    add(0, 0, 32'h0,         1, 32'hC,   1, 32'hC,   0, 32'h3333_3333, 32'hC,   0, 3);
    add(0, 0, 32'h0,         0, 32'hC,   1, 32'hC,   0, 32'h3333_3333, 32'hC,   0, 3);
    add(0, 1, 32'h4444_4444, 0, 32'hC,   1, 32'hC,   0, 32'h3333_3333, 32'hC,   0, 3);
    add(0, 0, 32'h0,         0, 32'h40,  0, 32'hC,   1, 32'h4444_4444, 32'hC,   0, 3);
    add(0, 1, 32'h5555_5555, 1, 32'h40,  1, 32'h40,  0, 32'h4444_4444, 32'h40,  0, 4);
    for (int i = 0; i < 5; i++)
      add(0, 1, 32'hDEAD_0000 + i, 1, 32'h100, 0, 32'h40, 1, 32'h5555_5555, 32'h40, 0, 4);
    add(0, 0, 32'h0,         0, 32'h100, 0, 32'h40,  1, 32'h5555_5555, 32'h40,  0, 4);
    add(0, 1, 32'h6666_6666, 0, 32'h0,   1, 32'h100, 0, 32'h5555_5555, 32'h100, 0, 5);
    add(0, 0, 32'h0,         0, 32'h102, 0, 32'h100, 1, 32'h6666_6666, 32'h100, 0, 5);
    add(0, 1, 32'h7777_7777, 0, 32'h0,   0, 32'h102, 0, 32'h6666_6666, 32'h102, 1, 6);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].rd, vecs[i].st, vecs[i].npc);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                vecs[i].e_inst, vecs[i].e_pc, vecs[i].e_fault, vecs[i].e_cnt);
      tick();
    end

    // Fault is terminal: no requests for 20 cycles whatever the inputs do
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, $urandom, 1'($urandom_range(0, 1)), $urandom);
      #1;
      check_all($sformatf("fault_hold%0d", i), 0, 32'h102, 0, 32'h6666_6666, 32'h102, 1, 6);
      tick();
    end

    // Reset leaves FAULT and restarts at RESET_PC
    drive(1, 1, 32'h0, 0, 32'h0);
    #1;
    chk1("fault_reset.imem_req", imem_req, 0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    #1;
    check_all("after_fault_reset", 1, RPC, 0, 32'h0, RPC, 0, 0);
    tick();

    // Reset mid-fetch with a response on the same cycle
    drive(0, 1, 32'hCAFE_0000, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h200);
    #1;
    chk1("midfetch.pre_valid", fetch_valid, 1);
    tick();
    drive(1, 1, 32'hDEAD_BEEF, 0, 32'h0);
    #1;
    chk1("midfetch.req_in_reset", imem_req, 0);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    #1;
    check_all("midfetch", 1, RPC, 0, 32'h0, RPC, 0, 0);
    tick();

    // Reset in VALID with stall=0 must not count a handoff
    drive(0, 1, 32'h1234_5678, 0, 32'h0);
    tick();
    drive(1, 0, 32'h0, 0, 32'h300);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    #1;
    check_all("reset_in_valid", 1, RPC, 0, 32'h0, RPC, 0, 0);
    tick();

    // Counter wrap via preload while stalled in VALID
    drive(0, 1, 32'hABCD_0000, 0, 32'h0);
    tick();
    drive(0, 0, 32'h0, 1, 32'h8);
    force dut.instr_count = 32'hFFFF_FFFF;
    tick();
    release dut.instr_count;
    #1;
    chk("wrap.preload", instr_count, 32'hFFFF_FFFF);
    tick();
    drive(0, 0, 32'h0, 0, 32'h8);
    tick();
    drive(0, 0, 32'h0, 0, 32'h0);
    #1;
    check_all("wrap", 1, 32'h8, 0, 32'hABCD_0000, 32'h8, 0, 32'h0);
    tick();

    // Randomized run against the reference model
    drive(1, 0, 32'h0, 0, 32'h0);
    tick();
    model_clock(1, 0, 32'h0, 0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      r_rst = ($urandom_range(0, 39) == 0);
      r_rdy = 1'($urandom_range(0, 1));
      r_st  = ($urandom_range(0, 2) == 0);
      r_rd  = $urandom;
      r_npc = $urandom;
      if ($urandom_range(0, 15) != 0) r_npc[1:0] = 2'b00;
      drive(r_rst, r_rdy, r_rd, r_st, r_npc);
      #1;
      check_all($sformatf("rand%0d", i), !r_rst && !m_hold && !m_fault, m_pc, m_hold,
                m_inst, m_pc, m_fault, m_cnt);
      tick();
      model_clock(r_rst, r_rdy, r_rd, r_st, r_npc);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage that sits directly upstream of the decode stage. It owns the architectural program counter and issues word reads to instruction memory with a request/ready handshake. It presents the fetched word and its PC to decode, holds them stable while decode computes the next PC, and then loads that next PC. A misaligned next PC halts fetching and raises a fault.

## Interface

Parameters:

- RESET_PC, 32'h0000_0000, PC loaded on reset. Must be word-aligned.

Ports:

- clk  in  1  single clock. Every register updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  32  read address. Always equals pc.
- imem_ready  in  1  memory has data on imem_rdata this cycle. Ignored unless imem_req=1.
- imem_rdata  in  32  instruction word.
- next_pc  in  32  PC of the following instruction, supplied by decode from the current i_fetch/pc.
- stall  in  1  downstream cannot accept the current instruction.
- i_fetch  out  32  registered instruction word presented to decode.
- pc  out  32  registered PC of the instruction in i_fetch, or of the word being fetched.
- fetch_valid  out  1  i_fetch/pc hold a valid instruction.
- fetch_fault  out  1  sticky. Set when a misaligned next_pc was taken.
- instr_count  out  32  count of instructions handed off to decode.

## Operation

The block is a three-state FSM: FETCH, VALID, FAULT.

- **Reset:**
  - state=FETCH, pc=RESET_PC, i_fetch=32'h0 (NOP), fetch_valid=0, fetch_fault=0, instr_count=0, imem_req=0.
  - imem_req is forced 0 in any cycle where reset=1.
- **FETCH:**
  - imem_req=1, imem_addr=pc.
  - On imem_ready=1: i_fetch<=imem_rdata, fetch_valid<=1, go to VALID.
  - Otherwise stay, with req and addr held stable.
- **VALID:**
  - imem_req=0. i_fetch and pc are held, so decode's next_pc is stable.
  - A handoff occurs when stall=0:
    - instr_count<=instr_count+1, with modulo-2^32 wrap.
    - fetch_valid<=0.
    - If next_pc[1:0]==2'b00: pc<=next_pc, go to FETCH.
    - Otherwise: pc<=next_pc (the offending value, kept for debug), fetch_fault<=1, go to FAULT.
  - When stall=1: nothing changes. The stage holds indefinitely.
- **FAULT:**
  - imem_req=0, fetch_valid=0, fetch_fault=1.
  - pc and i_fetch are frozen. Only reset exits this state.
- **Arithmetic:** the block does no PC arithmetic; next_pc is taken verbatim. instr_count is plain 32-bit unsigned and wraps from 32'hFFFF_FFFF to 0.
- **imem_rdata** is sampled only in FETCH with imem_ready=1. Values at any other time have no effect.

## Timing

- **Zero-wait memory** (imem_ready=1 in the same cycle as the request):
  - Cycle t: FETCH.
  - Cycle t+1: VALID with fetch_valid=1.
  - Cycle t+1 with no stall: handoff.
  - Cycle t+2: FETCH of the next_pc word.
  - Throughput is one instruction per 2 cycles.
- **N wait cycles** add exactly N cycles per instruction.
- **Outputs:**
  - i_fetch, pc, fetch_valid, fetch_fault and instr_count are registered.
  - imem_req and imem_addr are decoded from state and pc, so they have no combinational path from any input except reset.
- **Reset arriving mid-FETCH** (request outstanding, imem_ready may be 1 in the same cycle): the response is discarded. The next cycle is FETCH of RESET_PC.
- **Reset arriving in VALID with stall=0:** no handoff occurs and instr_count is not incremented.
- **stall during FETCH:** no effect. Stall is consulted only in VALID.
- **First request:** the first cycle after reset deasserts has imem_req=1 with imem_addr=RESET_PC.

## Test plan

- **Reset then straight-line run:** RESET_PC=0, zero-wait memory returning words 0x11111111, 0x22222222, 0x33333333 at addresses 0/4/8, next_pc=pc+4.
  - imem_addr must be 0, 4, 8 on cycles 1, 3, 5 after reset.
  - fetch_valid must pulse on cycles 2, 4, 6 carrying those words.
  - instr_count must read 3 at cycle 7.
- **Wait states:** imem_ready delayed 3 cycles.
  - imem_req and imem_addr must stay constant for 4 cycles.
  - fetch_valid must rise on the cycle after ready.
- **Stall hold:** assert stall for 5 cycles while in VALID at pc=0x40.
  - pc, i_fetch and fetch_valid=1 must be unchanged.
  - imem_req=0 and instr_count must not increment.
  - Release stall: next cycle is FETCH at next_pc.
- **Jump and misalignment:**
  - next_pc=0x100 must produce imem_addr=0x100.
  - A later next_pc=0x102 must produce fetch_fault=1, pc=0x102, imem_req=0, and no further requests for 20 cycles.
  - Reset must then clear fetch_fault and restart at RESET_PC.
- **Reset mid-fetch:** assert reset in the same cycle as imem_ready=1 with rdata=0xDEADBEEF.
  - i_fetch must be 0 and fetch_valid must be 0.
  - The next imem_addr must be RESET_PC.
- **Counter wrap:** force 2^32 handoffs (or preload via hierarchical force to 32'hFFFF_FFFF).
  - One more handoff must give instr_count=0.
